// File: rtl/wb_pkg.sv
// Shared write-back buffer types and processor-wide width defaults.
package wb_pkg;

   localparam int WB_DATA_W = 32;
   localparam int WB_ADDR_W = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      HALT  = 2'd2
   } wb_state_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous capture FIFO with wrap-bit pointers, flush and same-cycle push/pop.
module wb_fifo #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [AW:0]      count_o
);

   logic [AW:0]      wptr_q, wptr_d;
   logic [AW:0]      rptr_q, rptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign count_o = wptr_q - rptr_q;
   assign full_o  = (count_o == (AW+1)'(DEPTH));
   assign empty_o = (wptr_q == rptr_q);
   assign data_o  = mem_q[rptr_q[AW-1:0]];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (flush_i) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (do_push) wptr_d = wptr_q + 1'b1;
         if (do_pop)  rptr_d = rptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Storage needs no reset: pointers define which entries are valid.
   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) mem_q[wptr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/result_wb_buffer.sv
// Buffers WB-stage results and drains them to the result memory
// at sequential addresses over a write/ack handshake.
module result_wb_buffer
   import wb_pkg::*;
#(
   parameter int DATA_WIDTH = WB_DATA_W,
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_WIDTH = WB_ADDR_W,
   parameter int MEM_DEPTH  = 1024,
   parameter int WRAP_EN    = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        clear,
   input  logic                        in_valid,
   input  logic [DATA_WIDTH-1:0]       in_data,
   output logic                        in_ready,
   output logic                        mem_wr_en,
   output logic [ADDR_WIDTH-1:0]       mem_addr,
   output logic [DATA_WIDTH-1:0]       mem_wdata,
   input  logic                        mem_ack,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        mem_full,
   output logic                        overflow_err,
   output logic [31:0]                 wr_count
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

   wb_state_t             state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  wr_en_q, wr_en_d;
   logic                  full_q, full_d;
   logic                  ovf_q, ovf_d;
   logic [31:0]           wrcnt_q, wrcnt_d;

   logic                  fifo_full, fifo_empty, pop, push;
   logic [DATA_WIDTH-1:0] fifo_data;

   assign in_ready = !fifo_full;
   assign push     = in_valid && in_ready && !clear;

   wb_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .flush_i (clear),
      .push_i  (push),
      .data_i  (in_data),
      .pop_i   (pop),
      .data_o  (fifo_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wr_en_d = wr_en_q;
      full_d  = full_q;
      ovf_d   = ovf_q;
      wrcnt_d = wrcnt_q;
      pop     = 1'b0;
      if (clear) begin
         state_d = IDLE;
         addr_d  = '0;
         wr_en_d = 1'b0;
         full_d  = 1'b0;
         ovf_d   = 1'b0;
         wrcnt_d = '0;
      end else begin
         if (in_valid && !in_ready) ovf_d = 1'b1;
         unique case (state_q)
            IDLE: begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  wdata_d = fifo_data;
                  wr_en_d = 1'b1;
                  state_d = WRITE;
               end
            end
            WRITE: begin
               if (mem_ack) begin
                  wrcnt_d = wrcnt_q + 32'd1;
                  if (addr_q == LAST_ADDR && WRAP_EN == 0) begin
                     wr_en_d = 1'b0;
                     full_d  = 1'b1;
                     state_d = HALT;
                  end else begin
                     if (addr_q == LAST_ADDR) begin
                        addr_d = '0;
                        full_d = 1'b1;
                     end else begin
                        addr_d = addr_q + 1'b1;
                     end
                     // Refill straight from the FIFO for 1 write/cycle.
                     if (!fifo_empty) begin
                        pop     = 1'b1;
                        wdata_d = fifo_data;
                     end else begin
                        wr_en_d = 1'b0;
                        state_d = IDLE;
                     end
                  end
               end
            end
            HALT: ;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         wr_en_q <= 1'b0;
         full_q  <= 1'b0;
         ovf_q   <= 1'b0;
         wrcnt_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wr_en_q <= wr_en_d;
         full_q  <= full_d;
         ovf_q   <= ovf_d;
         wrcnt_q <= wrcnt_d;
      end
   end

   assign mem_wr_en    = wr_en_q;
   assign mem_addr     = addr_q;
   assign mem_wdata    = wdata_q;
   assign mem_full     = full_q;
   assign overflow_err = ovf_q;
   assign wr_count     = wrcnt_q;

endmodule

// File: tb/tb_result_wb_buffer.sv
// Scoreboard bench for result_wb_buffer: default, halt-at-4 and wrap-at-4 variants.
module tb_result_wb_buffer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr [3];
   logic        iv  [3];
   logic        ack [3];
   logic [31:0] id  [3];
   logic        ird [3];
   logic        wen [3];
   logic [9:0]  ad  [3];
   logic [31:0] wd  [3];
   logic [3:0]  fc  [3];
   logic        mf  [3];
   logic        ovf [3];
   logic [31:0] wc  [3];

   int n_chk = 0;
   int n_pass = 0;
   int act = 0;
   int maddr = 0;
   bit halted = 1'b0;
   int dep [3] = '{1024, 4, 4};
   bit wrp [3] = '{1'b1, 1'b0, 1'b1};
   logic [31:0] sbq [$];
   logic [31:0] exp_w;

   result_wb_buffer #(
      .DATA_WIDTH(32), .FIFO_DEPTH(8), .ADDR_WIDTH(10),
      .MEM_DEPTH(1024), .WRAP_EN(1)
   ) u0 (
      .clk(clk), .rst_n(rst_n), .clear(clr[0]),
      .in_valid(iv[0]), .in_data(id[0]), .in_ready(ird[0]),
      .mem_wr_en(wen[0]), .mem_addr(ad[0]), .mem_wdata(wd[0]),
      .mem_ack(ack[0]), .fifo_count(fc[0]), .mem_full(mf[0]),
      .overflow_err(ovf[0]), .wr_count(wc[0])
   );

   result_wb_buffer #(
      .DATA_WIDTH(32), .FIFO_DEPTH(8), .ADDR_WIDTH(10),
      .MEM_DEPTH(4), .WRAP_EN(0)
   ) u1 (
      .clk(clk), .rst_n(rst_n), .clear(clr[1]),
      .in_valid(iv[1]), .in_data(id[1]), .in_ready(ird[1]),
      .mem_wr_en(wen[1]), .mem_addr(ad[1]), .mem_wdata(wd[1]),
      .mem_ack(ack[1]), .fifo_count(fc[1]), .mem_full(mf[1]),
      .overflow_err(ovf[1]), .wr_count(wc[1])
   );

   result_wb_buffer #(
      .DATA_WIDTH(32), .FIFO_DEPTH(8), .ADDR_WIDTH(10),
      .MEM_DEPTH(4), .WRAP_EN(1)
   ) u2 (
      .clk(clk), .rst_n(rst_n), .clear(clr[2]),
      .in_valid(iv[2]), .in_data(id[2]), .in_ready(ird[2]),
      .mem_wr_en(wen[2]), .mem_addr(ad[2]), .mem_wdata(wd[2]),
      .mem_ack(ack[2]), .fifo_count(fc[2]), .mem_full(mf[2]),
      .overflow_err(ovf[2]), .wr_count(wc[2])
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int k, input logic [31:0] d);
      iv[k] = 1'b1;
      id[k] = d;
      step();
      iv[k] = 1'b0;
   endtask

   task automatic pulse_clear(input int k);
      clr[k] = 1'b1;
      step();
      clr[k] = 1'b0;
   endtask

   task automatic wait_idle(input int k);
      int n = 0;
      while ((wen[k] || fc[k] != 0) && n < 50) begin
         step();
         n++;
      end
      chk("drain_timeout", n < 50, 1);
   endtask

   // Inputs change 1ns after posedge, so negedge sees what the next edge uses.
   always @(negedge clk) begin
      if (rst_n) begin
         if (clr[act]) begin
            sbq.delete();
            maddr = 0;
            halted = 1'b0;
         end else begin
            if (iv[act] && ird[act]) sbq.push_back(id[act]);
            if (wen[act] && ack[act]) begin
               chk("no_wr_after_halt", halted, 0);
               chk("sb_nonempty", sbq.size() > 0, 1);
               if (sbq.size() > 0) begin
                  exp_w = sbq.pop_front();
                  chk("wdata", wd[act], exp_w);
                  chk("waddr", ad[act], maddr);
               end
               maddr++;
               if (maddr == dep[act]) begin
                  maddr = 0;
                  if (!wrp[act]) halted = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < 3; k++) begin
         clr[k] = 1'b0;
         iv[k]  = 1'b0;
         ack[k] = 1'b0;
         id[k]  = '0;
      end
      #1;
      chk("rst_wen", wen[0], 0);
      chk("rst_addr", ad[0], 0);
      chk("rst_wdata", wd[0], 0);
      chk("rst_fc", fc[0], 0);
      chk("rst_full", mf[0], 0);
      chk("rst_ovf", ovf[0], 0);
      chk("rst_wc", wc[0], 0);
      chk("rst_ready", ird[0], 1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      step();

      // single word, ack tied high
      act = 0;
      ack[0] = 1'b1;
      push(0, 32'h0000_00AA);
      chk("t1_fc", fc[0], 1);
      chk("t1_wen0", wen[0], 0);
      step();
      chk("t1_wen1", wen[0], 1);
      chk("t1_addr", ad[0], 0);
      chk("t1_data", wd[0], 32'hAA);
      step();
      chk("t1_wen_done", wen[0], 0);
      chk("t1_wc", wc[0], 1);
      chk("t1_fc_done", fc[0], 0);

      // fill under back-pressure: one word in hold, eight in the FIFO
      pulse_clear(0);
      chk("t2_clr_wc", wc[0], 0);
      chk("t2_clr_addr", ad[0], 0);
      ack[0] = 1'b0;
      for (int i = 1; i <= 9; i++) push(0, 32'(i));
      chk("t2_fc", fc[0], 8);
      chk("t2_ready", ird[0], 0);
      chk("t2_ovf", ovf[0], 0);
      chk("t2_wen", wen[0], 1);
      chk("t2_hold", wd[0], 1);

      // overflow drop, then back-to-back drain
      push(0, 32'hDEAD);
      chk("t3_ovf", ovf[0], 1);
      chk("t3_fc", fc[0], 8);
      ack[0] = 1'b1;
      begin
         int cyc = 0;
         while (wen[0] && cyc < 40) begin
            step();
            cyc++;
         end
         chk("t3_b2b_cycles", cyc, 9);
      end
      wait_idle(0);
      chk("t3_ovf_sticky", ovf[0], 1);
      chk("t3_wc", wc[0], 9);
      chk("t3_sb_drained", sbq.size(), 0);

      // clear wins over a same-cycle push
      iv[0] = 1'b1;
      id[0] = 32'h55;
      pulse_clear(0);
      iv[0] = 1'b0;
      chk("clr_ovf", ovf[0], 0);
      chk("clr_fc", fc[0], 0);
      chk("clr_wc", wc[0], 0);
      chk("clr_ready", ird[0], 1);
      step();
      chk("clr_no_write", wen[0], 0);

      // halt at end of a 4-word memory
      act = 1;
      ack[1] = 1'b1;
      for (int i = 0; i < 6; i++) push(1, 32'h100 + 32'(i));
      repeat (12) step();
      chk("t4_full", mf[1], 1);
      chk("t4_fc", fc[1], 2);
      chk("t4_wen", wen[1], 0);
      chk("t4_addr", ad[1], 3);
      chk("t4_wc", wc[1], 4);
      for (int i = 0; i < 6; i++) push(1, 32'h200 + 32'(i));
      chk("t4_halt_fc", fc[1], 8);
      chk("t4_halt_ready", ird[1], 0);
      pulse_clear(1);
      chk("t4_clr_addr", ad[1], 0);
      chk("t4_clr_fc", fc[1], 0);
      chk("t4_clr_full", mf[1], 0);
      chk("t4_clr_wen", wen[1], 0);

      // wrap in a 4-word memory
      act = 2;
      ack[2] = 1'b1;
      for (int i = 0; i < 5; i++) push(2, 32'h300 + 32'(i));
      wait_idle(2);
      chk("t5_wc", wc[2], 5);
      chk("t5_full", mf[2], 1);
      chk("t5_addr", ad[2], 1);

      // async reset in the middle of a pending write
      act = 0;
      ack[0] = 1'b0;
      push(0, 32'h77);
      step();
      chk("t6_pending", wen[0], 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_wen", wen[0], 0);
      chk("t6_addr", ad[0], 0);
      chk("t6_wdata", wd[0], 0);
      chk("t6_fc", fc[0], 0);
      chk("t6_wc", wc[0], 0);
      chk("t6_ready", ird[0], 1);
      sbq.delete();
      maddr = 0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      ack[0] = 1'b1;
      repeat (3) step();
      chk("t6_no_ack_wc", wc[0], 0);
      chk("t6_idle", wen[0], 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
